// File: rtl/audio_pkg.sv
// Shared types for the key tone generator: FSM states, the release code and the
// scan-code lookup that yields the note index and half-period in clock cycles.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_GAP    = 2'd1,
        ST_PLAY   = 2'd2
    } state_e;

    localparam logic [7:0] KEY_RELEASE = 8'hF0;

    typedef struct packed {
        logic        valid;
        logic [3:0]  idx;
        logic [16:0] half;
    } note_info_t;

    // Half-periods assume a 50 MHz clock.
    function automatic note_info_t decode_key(input logic [7:0] code);
        note_info_t n;
        n = '0;
        case (code)
            8'h2B: n = {1'b1, 4'd1,  17'd95555};
            8'h34: n = {1'b1, 4'd2,  17'd85133};
            8'h33: n = {1'b1, 4'd3,  17'd75843};
            8'h3B: n = {1'b1, 4'd4,  17'd71586};
            8'h42: n = {1'b1, 4'd5,  17'd63776};
            8'h4B: n = {1'b1, 4'd6,  17'd56818};
            8'h4C: n = {1'b1, 4'd7,  17'd50620};
            8'h52: n = {1'b1, 4'd8,  17'd47778};
            8'h1C: n = {1'b1, 4'd9,  17'd127551};
            8'h1B: n = {1'b1, 4'd10, 17'd113636};
            default: n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter and phase toggle. A load restarts the waveform at phase 1
// with a fresh count; dropping enable parks the divider at zero.
module tone_divider
    import audio_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        enable,
    input  logic [16:0] load_div,
    output logic        phase
);

    logic [16:0] div_q;
    logic [16:0] cnt_q;
    logic        phase_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (load) begin
            div_q   <= load_div;
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (!enable) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q >= div_q - 17'd1) begin
            // >= rather than == keeps the count bounded even if div_q were corrupted
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + 17'd1;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/key_tone_gen.sv
// Turns scan codes from the song player into a square-wave tone and signed codec
// samples, inserting a short silent gap between directly adjacent different notes.
module key_tone_gen
    import audio_pkg::*;
#(
    parameter int                 CLK_HZ     = 50000000,
    parameter int                 GAP_CYCLES = 1000,
    parameter logic signed [15:0] AMPLITUDE  = 16'sh2000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         key_code,
    input  logic               mute,
    output logic               tone_out,
    output logic signed [15:0] sample,
    output logic               note_valid,
    output logic [3:0]         note_idx,
    output logic [1:0]         fsm_state
);

    // Pitches are only right at 50 MHz; any other clock keeps the block silent.
    localparam bit TABLE_OK = (CLK_HZ == 50000000);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [7:0]       key_q;
    state_e           state_q;
    state_e           state_d;
    note_info_t       info;
    logic             key_ok;
    logic             enter_play;
    logic             enter_gap;
    logic             playing;
    logic             phase;
    logic [3:0]       idx_q;
    logic [GAP_W-1:0] gap_q;

    assign info   = decode_key(key_q);
    assign key_ok = info.valid && TABLE_OK;

    always_comb begin
        state_d    = state_q;
        enter_play = 1'b0;
        enter_gap  = 1'b0;
        case (state_q)
            ST_SILENT: begin
                if (key_ok) begin
                    state_d    = ST_PLAY;
                    enter_play = 1'b1;
                end
            end
            ST_PLAY: begin
                if (!key_ok) begin
                    state_d = ST_SILENT;
                end else if (info.idx != idx_q) begin
                    if (GAP_CYCLES == 0) begin
                        enter_play = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        enter_gap = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (!key_ok) begin
                    state_d = ST_SILENT;
                end else if (gap_q == '0) begin
                    state_d    = ST_PLAY;
                    enter_play = 1'b1;
                end
            end
            default: state_d = ST_SILENT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_q   <= KEY_RELEASE;
            state_q <= ST_SILENT;
            idx_q   <= '0;
            gap_q   <= '0;
        end else begin
            key_q   <= key_code;
            state_q <= state_d;
            if (enter_play) idx_q <= info.idx;
            if (enter_gap) begin
                gap_q <= GAP_W'(GAP_CYCLES - 1);
            end else if (state_q == ST_GAP && gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end
        end
    end

    tone_divider u_divider (
        .clock    (clock),
        .reset    (reset),
        .load     (enter_play),
        .enable   (state_q == ST_PLAY),
        .load_div (info.half),
        .phase    (phase)
    );

    // mute gates only the outputs so the waveform keeps its place underneath
    assign playing    = (state_q == ST_PLAY);
    assign tone_out   = phase && playing && !mute;
    assign sample     = (!playing || mute) ? 16'sd0 : (phase ? AMPLITUDE : -AMPLITUDE);
    assign note_valid = playing;
    assign note_idx   = playing ? idx_q : 4'd0;
    assign fsm_state  = state_q;

endmodule

// File: doc/key_tone_gen.md
KEY_TONE_GEN -- requirements
Module: key_tone_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000; system clock frequency; the divisor table is valid only for this value.
REQ-002 SHALL have parameter GAP_CYCLES, default 1000; silent gap inserted between two directly adjacent different notes.
REQ-003 SHALL have parameter AMPLITUDE, default 16'sh2000; magnitude of the output sample.
REQ-004 SHALL have port clock, input, 1, single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port key_code, input, 8, scan code from the upstream song player; 8'hF0 means release/silence.
REQ-007 SHALL have port mute, input, 1, forces silent outputs without disturbing timing.
REQ-008 SHALL have port tone_out, output, 1, square wave for a 1-bit speaker pin.
REQ-009 SHALL have port sample, output, 16 signed, audio-codec sample +AMPLITUDE, -AMPLITUDE or 0.
REQ-010 SHALL have port note_valid, output, 1, high while in PLAY.
REQ-011 SHALL have port note_idx, output, 4, index of the playing note 1..10; 0 when not playing.

Function
REQ-012 SHALL register key_code into key_q every cycle.
REQ-013 SHALL decode key_q per this table: 2B->1 C4 95555; 34->2 D4 85133; 33->3 E4 75843; 3B->4 F4 71586; 42->5 G4 63776; 4B->6 A4 56818; 4C->7 B4 50620; 52->8 C5 47778; 1C->9 G3 127551; 1B->10 A3 113636. Each value is a 17-bit half-period in clock cycles.
REQ-014 SHALL treat every other code, including F0, as silence.
REQ-015 SHALL implement an FSM with states SILENT, GAP and PLAY.
REQ-016 FSM transitions SHALL be: SILENT + valid code -> PLAY; PLAY + same code -> PLAY; PLAY + silence code -> SILENT; PLAY + different valid code -> GAP.
REQ-017 On each GAP entry, the gap counter SHALL reload to GAP_CYCLES-1.
REQ-018 On GAP expiry, the FSM SHALL go to PLAY if the current key_q is valid, otherwise to SILENT.
REQ-019 A silence code during GAP SHALL send the FSM to SILENT at once.
REQ-020 With GAP_CYCLES=0, a note change SHALL go PLAY->PLAY directly.
REQ-021 On every PLAY entry, the block SHALL latch the divisor and note_idx, clear the period counter and set phase=1.
REQ-022 In PLAY, the period counter SHALL count 0..div-1; at div-1 it wraps to 0 and phase toggles. Output period is therefore 2*div cycles.
REQ-023 Latency SHALL be 2 cycles: a key_code change at edge n appears on the outputs after edge n+2.
REQ-024 tone_out SHALL equal phase AND PLAY AND NOT mute.
REQ-025 sample SHALL be 0 when mute is high or the state is not PLAY; otherwise +AMPLITUDE when phase=1 and -AMPLITUDE when phase=0.
REQ-026 mute SHALL take effect in the same cycle (combinational gate on registered state) and SHALL NOT stop the counter or phase.
REQ-027 Counter arithmetic SHALL be 17-bit unsigned and SHALL never exceed div-1.

Reset
REQ-028 While reset is high, the block SHALL hold state=SILENT, key_q=8'hF0, counters=0 and phase=0.
REQ-029 Outputs during reset SHALL be tone_out=0, sample=0, note_valid=0, note_idx=0.
REQ-030 Reset asserted mid-note or mid-gap SHALL abort immediately at the next edge; after release the first note follows REQ-023.

Structure
REQ-031 Package audio_pkg SHALL hold the FSM state enum, the F0 release constant and the scan-code-to-{idx, half-period} table as a function.
REQ-032 The block SHALL contain one sub-module, tone_divider, covering the period counter and phase toggle with load/enable inputs.

Verification
REQ-033 Reset, then key_code=8'h4B held: note_idx=6 and note_valid=1 two cycles later; tone_out high 56818 cycles then low 56818 cycles; sample alternates +8192/-8192.
REQ-034 Playing 8'h2B, then key_code=8'hF0: two cycles later note_valid=0, tone_out=0, sample=0, note_idx=0.
REQ-035 Playing 8'h2B, then key_code=8'h34 directly: GAP with all outputs silent for exactly 1000 cycles, then note_idx=2, phase=1 and a fresh counter.
REQ-036 Playing 8'h1C with mute toggled mid-period: outputs zero while muted; on unmute phase resumes with period 255102 unaltered.
REQ-037 Unknown code 8'h77 from SILENT: state stays SILENT; reset pulsed mid-note on 8'h52: outputs 0 on the following edge.
